// File: rtl/rr_arb4_sel.sv
// Four-requester round-robin arbiter driving the registered 2-bit select (a,b)
// of a downstream 2-to-4 decoder, with hold timeout and grant qualifier.
module rr_arb4_sel #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       a,
  output logic       b,
  output logic       grant_valid,
  output logic       timeout_flag
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           r_state;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gv;
  logic             r_to;

  logic [1:0]       w_winner;
  logic             w_owner_req;
  logic             w_norm_rel;
  logic             w_limit;

  // First set request bit scanning upward from ptr, wrapping 3 -> 0.
  function automatic logic [1:0] pick_winner(input logic [3:0] rq, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    pick_winner = ptr;
    found       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && rq[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  assign w_winner    = pick_winner(req, r_ptr);
  assign w_owner_req = req[r_sel];
  assign w_norm_rel  = done || !w_owner_req;
  assign w_limit     = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_gv    <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_to <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req != 4'd0) begin
            r_sel   <= w_winner;
            r_cnt   <= '0;
            r_gv    <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_norm_rel || w_limit) begin
            r_state <= IDLE;
            r_gv    <= 1'b0;
            r_ptr   <= r_sel + 2'd1;
            // Flag only a release forced by the hold limit alone.
            r_to    <= !w_norm_rel;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gv    <= 1'b0;
        end
      endcase
    end
  end

  assign a            = r_sel[1];
  assign b            = r_sel[0];
  assign grant_valid  = r_gv;
  assign timeout_flag = r_to;

endmodule
